apb_protocol_checker: RTL and testbench

- Synthesizable, parametrised APB protocol monitor for NB_CH independent APB channels.
- Each channel has its own PSEL/PENABLE/PWRITE/PREADY/PADDR.
- Tracks each channel's transfer phase with a small FSM, flags protocol violations with coded error pulses and sticky flags, and counts completed reads/writes and total errors.
- Sits passively on the APB fabric in both simulation and emulation builds. It replaces the bind-only assertion and cover checks for these rules.

---
 rtl/apb_protocol_checker.sv | 245 ++++++++++++++++++++++++
 tb/tb_apb_protocol_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol monitor for NB_CH independent channels. It tracks each channel's
// transfer phase, reports coded violations, and keeps saturating transfer and error counters.
module apb_protocol_checker #(
  parameter int NB_CH   = 2,
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  localparam int CH_W   = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
  input  logic                      ckApb,
  input  logic                      rstApb,
  input  logic                      en,
  input  logic                      clr,
  input  logic [NB_CH-1:0]          apbPSel,
  input  logic [NB_CH-1:0]          apbPEnable,
  input  logic [NB_CH-1:0]          apbPWrite,
  input  logic [NB_CH-1:0]          apbPReady,
  input  logic [NB_CH*ADDR_W-1:0]   apbPAddr,
  output logic                      errValid,
  output logic [CH_W-1:0]           errChan,
  output logic [2:0]                errCode,
  output logic [NB_CH*5-1:0]        errSticky,
  output logic [CNT_W-1:0]          errorCnt,
  output logic [NB_CH*CNT_W-1:0]    rdCnt,
  output logic [NB_CH*CNT_W-1:0]    wrCnt,
  output logic [NB_CH-1:0]          busy
);

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int NW     = $clog2(NB_CH + 1);
  localparam int ESUM_W = ((CNT_W > NW) ? CNT_W : NW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                         state_r [NB_CH];
  state_t                         state_s [NB_CH];
  logic [NB_CH-1:0][ADDR_W-1:0]   addr_r, addr_s;
  logic [NB_CH-1:0][WAIT_W-1:0]   wait_r, wait_s;
  logic [NB_CH-1:0]               wr_r, wr_s;
  logic [NB_CH-1:0]               to_r, to_s;
  logic [NB_CH-1:0]               done_s;
  logic [NB_CH-1:0]               unstable_s;
  logic [NB_CH-1:0][4:0]          err_s;
  logic                           any_s;
  logic [CH_W-1:0]                chan_s;
  logic [2:0]                     code_s;
  logic [NW-1:0]                  nerr_s;
  logic [ESUM_W-1:0]              esum_s;

  // Lowest set error bit wins when one channel raises several codes in a cycle.
  function automatic logic [2:0] err_code(input logic [4:0] e);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (e[k]) begin
        c = 3'(k + 1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Per-channel transfer FSM: next state, captured setup values and error bits.
  always_comb begin
    for (int i = 0; i < NB_CH; i++) begin
      state_s[i]    = state_r[i];
      addr_s[i]     = addr_r[i];
      wr_s[i]       = wr_r[i];
      wait_s[i]     = wait_r[i];
      to_s[i]       = to_r[i];
      err_s[i]      = 5'd0;
      done_s[i]     = 1'b0;
      unstable_s[i] = (apbPAddr[i*ADDR_W +: ADDR_W] != addr_r[i]) || (apbPWrite[i] != wr_r[i]);

      case (state_r[i])
        ST_IDLE: begin
          if (apbPEnable[i]) begin
            err_s[i][0] = 1'b1;
          end else if (apbPSel[i]) begin
            state_s[i] = ST_SETUP;
            addr_s[i]  = apbPAddr[i*ADDR_W +: ADDR_W];
            wr_s[i]    = apbPWrite[i];
          end else begin
            state_s[i] = ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (apbPSel[i] && apbPEnable[i]) begin
            err_s[i][2] = unstable_s[i];
            if (apbPReady[i]) begin
              done_s[i]  = 1'b1;
              state_s[i] = ST_IDLE;
            end else begin
              state_s[i] = ST_ACCESS;
              wait_s[i]  = WAIT_W'(1);
              to_s[i]    = 1'b0;
            end
          end else begin
            err_s[i][1] = 1'b1;
            if (apbPSel[i]) begin
              addr_s[i] = apbPAddr[i*ADDR_W +: ADDR_W];
              wr_s[i]   = apbPWrite[i];
            end else begin
              state_s[i] = ST_IDLE;
            end
          end
        end
        ST_ACCESS: begin
          if (apbPSel[i] && apbPEnable[i]) begin
            err_s[i][2] = unstable_s[i];
            if (apbPReady[i]) begin
              done_s[i]  = 1'b1;
              state_s[i] = ST_IDLE;
              wait_s[i]  = '0;
              to_s[i]    = 1'b0;
            end else begin
              // The wait counter parks at TIMEOUT; the flag keeps the timeout to one report.
              if ((TIMEOUT != 0) && !to_r[i] && ((int'(wait_r[i]) + 1) >= TIMEOUT)) begin
                err_s[i][4] = 1'b1;
                to_s[i]     = 1'b1;
              end else begin
                to_s[i] = to_r[i];
              end
              if (int'(wait_r[i]) < TIMEOUT) begin
                wait_s[i] = wait_r[i] + WAIT_W'(1);
              end else begin
                wait_s[i] = wait_r[i];
              end
            end
          end else begin
            err_s[i][3] = 1'b1;
            state_s[i]  = ST_IDLE;
            wait_s[i]   = '0;
            to_s[i]     = 1'b0;
          end
        end
        default: begin
          state_s[i] = ST_IDLE;
          wait_s[i]  = '0;
          to_s[i]    = 1'b0;
        end
      endcase

      if (!en) begin
        state_s[i] = ST_IDLE;
        wait_s[i]  = '0;
        to_s[i]    = 1'b0;
        err_s[i]   = 5'd0;
        done_s[i]  = 1'b0;
      end else begin
        done_s[i] = done_s[i];
      end
    end
  end

  // Error arbitration: lowest erroring channel is reported, all are counted.
  always_comb begin
    any_s  = 1'b0;
    chan_s = '0;
    code_s = 3'd0;
    nerr_s = '0;
    for (int i = NB_CH - 1; i >= 0; i--) begin
      if (|err_s[i]) begin
        any_s  = 1'b1;
        chan_s = CH_W'(i);
        code_s = err_code(err_s[i]);
        nerr_s = nerr_s + NW'(1);
      end else begin
        nerr_s = nerr_s;
      end
    end
    esum_s = ESUM_W'(errorCnt) + ESUM_W'(nerr_s);
  end

  // Channel activity straight from the state registers.
  always_comb begin
    busy = '0;
    for (int i = 0; i < NB_CH; i++) begin
      busy[i] = (state_r[i] != ST_IDLE);
    end
  end

  // FSM state, captured setup values, wait counters and timeout-reported flags.
  always_ff @(posedge ckApb or posedge rstApb) begin
    if (rstApb) begin
      for (int i = 0; i < NB_CH; i++) begin
        state_r[i] <= ST_IDLE;
      end
      addr_r <= '0;
      wr_r   <= '0;
      wait_r <= '0;
      to_r   <= '0;
    end else begin
      for (int i = 0; i < NB_CH; i++) begin
        state_r[i] <= state_s[i];
      end
      addr_r <= addr_s;
      wr_r   <= wr_s;
      wait_r <= wait_s;
      to_r   <= to_s;
    end
  end

  // Registered error report, sticky flags and saturating counters; clr beats any update.
  always_ff @(posedge ckApb or posedge rstApb) begin
    if (rstApb) begin
      errValid  <= 1'b0;
      errChan   <= '0;
      errCode   <= 3'd0;
      errSticky <= '0;
      errorCnt  <= '0;
      rdCnt     <= '0;
      wrCnt     <= '0;
    end else begin
      errValid <= any_s;
      errChan  <= chan_s;
      errCode  <= code_s;
      if (clr) begin
        errSticky <= '0;
        errorCnt  <= '0;
        rdCnt     <= '0;
        wrCnt     <= '0;
      end else begin
        errorCnt <= (esum_s > ESUM_W'(CNT_MAX)) ? CNT_MAX : esum_s[CNT_W-1:0];
        for (int i = 0; i < NB_CH; i++) begin
          errSticky[i*5 +: 5] <= errSticky[i*5 +: 5] | err_s[i];
          if (done_s[i] && wr_r[i] && (wrCnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
            wrCnt[i*CNT_W +: CNT_W] <= wrCnt[i*CNT_W +: CNT_W] + CNT_W'(1);
          end else if (done_s[i] && !wr_r[i] && (rdCnt[i*CNT_W +: CNT_W] != CNT_MAX)) begin
            rdCnt[i*CNT_W +: CNT_W] <= rdCnt[i*CNT_W +: CNT_W] + CNT_W'(1);
          end else begin
            wrCnt[i*CNT_W +: CNT_W] <= wrCnt[i*CNT_W +: CNT_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker: error reports go through a scoreboard queue,
// counters and flags are compared against hand-computed values.
module tb_apb_protocol_checker;

  localparam int NB_CH   = 2;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 2;

  logic                    ckApb = 1'b0;
  logic                    rstApb, en, clr;
  logic [NB_CH-1:0]        apbPSel, apbPEnable, apbPWrite, apbPReady;
  logic [NB_CH*ADDR_W-1:0] apbPAddr;
  logic                    errValid;
  logic [0:0]              errChan;
  logic [2:0]              errCode;
  logic [NB_CH*5-1:0]      errSticky;
  logic [CNT_W-1:0]        errorCnt;
  logic [NB_CH*CNT_W-1:0]  rdCnt, wrCnt;
  logic [NB_CH-1:0]        busy;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_e;

  apb_protocol_checker #(
    .NB_CH(NB_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .ckApb(ckApb), .rstApb(rstApb), .en(en), .clr(clr),
    .apbPSel(apbPSel), .apbPEnable(apbPEnable), .apbPWrite(apbPWrite),
    .apbPReady(apbPReady), .apbPAddr(apbPAddr),
    .errValid(errValid), .errChan(errChan), .errCode(errCode),
    .errSticky(errSticky), .errorCnt(errorCnt), .rdCnt(rdCnt), .wrCnt(wrCnt),
    .busy(busy)
  );

  always #5 ckApb = ~ckApb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int c, input logic s, input logic p, input logic w,
                       input logic r, input logic [ADDR_W-1:0] a);
    apbPSel[c]    = s;
    apbPEnable[c] = p;
    apbPWrite[c]  = w;
    apbPReady[c]  = r;
    apbPAddr[c*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic idle_all();
    apbPSel = '0; apbPEnable = '0; apbPWrite = '0; apbPReady = '0; apbPAddr = '0;
  endtask

  task automatic cyc();
    @(posedge ckApb);
    #1;
  endtask

  // Monitor: every error pulse must match the oldest expected report.
  always @(negedge ckApb) begin
    if (errValid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual chan=%0d code=%0d required none", errChan, errCode);
      end else begin
        exp_e = sb_q.pop_front();
        if ({errChan, errCode} !== exp_e) begin
          errors++;
          $display("FAIL sb_report actual chan=%0d code=%0d required chan=%0d code=%0d",
                   errChan, errCode, exp_e[3], exp_e[2:0]);
        end
      end
    end
  end

  initial begin
    rstApb = 1'b1; en = 1'b1; clr = 1'b0;
    idle_all();
    cyc(); cyc();
    chk("rst_errvalid", 32'(errValid), 32'd0);
    chk("rst_errorcnt", 32'(errorCnt), 32'd0);
    chk("rst_cnts", 32'({rdCnt, wrCnt}), 32'd0);
    chk("rst_sticky", 32'(errSticky), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstApb = 1'b0;
    cyc();

    // Ch0 legal write with no wait states.
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0020); cyc();
    chk("wr0_busy_setup", 32'(busy), 32'd1);
    drive(0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0020); cyc();
    chk("wr0_busy_done", 32'(busy), 32'd0);
    chk("wr0_wrcnt", 32'(wrCnt[1:0]), 32'd1);
    idle_all(); cyc();
    chk("wr0_errorcnt", 32'(errorCnt), 32'd0);

    // Ch1 read with three wait states; timeout after the second.
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040); cyc();
    drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040); cyc();
    chk("to_no_early", 32'(errValid), 32'd0);
    sb_q.push_back({1'b1, 3'd5});
    cyc();
    chk("to_pulse", 32'(errValid), 32'd1);
    cyc();
    chk("to_once", 32'(errValid), 32'd0);
    drive(1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0040); cyc();
    idle_all(); cyc();
    chk("to_rdcnt1", 32'(rdCnt[3:2]), 32'd1);
    chk("to_errorcnt", 32'(errorCnt), 32'd1);
    chk("to_sticky", 32'(errSticky), 32'h200);
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("clr_errorcnt", 32'(errorCnt), 32'd0);
    chk("clr_sticky_rd", 32'({errSticky, rdCnt}), 32'd0);

    // Ch0 address changes in ACCESS while ch1 raises PENABLE without PSEL.
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010); cyc();
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0010); cyc();
    drive(0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0014);
    drive(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    sb_q.push_back({1'b0, 3'd3});
    cyc();
    chk("stab_errorcnt", 32'(errorCnt), 32'd2);
    chk("stab_sticky", 32'(errSticky), 32'h24);
    chk("stab_rdcnt0", 32'(rdCnt[1:0]), 32'd1);
    idle_all(); cyc();
    clr = 1'b1; cyc(); clr = 1'b0;

    // Ch0 PSEL drops in ACCESS, then two back-to-back legal reads.
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030); cyc();
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0030); cyc();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0030);
    sb_q.push_back({1'b0, 3'd4});
    cyc();
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_errorcnt", 32'(errorCnt), 32'd1);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0034); cyc();
    drive(0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0034); cyc();
    chk("drop_rdcnt_a", 32'(rdCnt[1:0]), 32'd1);
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0038); cyc();
    drive(0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0038); cyc();
    idle_all(); cyc();
    chk("b2b_rdcnt", 32'(rdCnt[1:0]), 32'd2);
    chk("b2b_errorcnt", 32'(errorCnt), 32'd1);
    clr = 1'b1; cyc(); clr = 1'b0;

    // Saturation of the 2-bit write counter, then clr against a completion.
    for (int k = 0; k < 5; k++) begin
      drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050); cyc();
      drive(0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0050); cyc();
    end
    chk("sat_wrcnt", 32'(wrCnt[1:0]), 32'd3);
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050); cyc();
    drive(0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0050);
    clr = 1'b1; cyc(); clr = 1'b0;
    idle_all(); cyc();
    chk("clr_wins_wrcnt", 32'(wrCnt), 32'd0);

    // Disabled monitor ignores a stray PENABLE.
    en = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); cyc(); cyc();
    chk("dis_errorcnt", 32'(errorCnt), 32'd0);
    chk("dis_sticky", 32'(errSticky), 32'd0);
    idle_all(); cyc();
    en = 1'b1; cyc();

    // Reset in the middle of a ch1 ACCESS.
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0060); cyc();
    drive(1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0060); cyc();
    chk("pre_rst_rdcnt1", 32'(rdCnt[3:2]), 32'd1);
    drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0064); cyc();
    drive(1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0064); cyc();
    chk("pre_rst_busy", 32'(busy), 32'h2);
    rstApb = 1'b1;
    idle_all();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnts", 32'({rdCnt, wrCnt}), 32'd0);
    chk("mid_rst_err", 32'({errValid, errorCnt, errSticky}), 32'd0);
    cyc();
    rstApb = 1'b0;
    cyc(); cyc(); cyc();
    chk("post_rst_errorcnt", 32'(errorCnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    cyc();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
